redmule_z_collector: RTL

- Output-side buffer between the RedMulE engine and the Z store streamer.
- Captures one engine output row per fill cycle while the controller asserts `z_fill` during its buffering phase.
- Raises `full` once the programmed row count is captured, then drains rows to the streamer over a valid/ready port and raises `empty` when the drain completes.
- Its flags feed the controller's buffering and storing transitions.

---
 rtl/redmule_z_collector_pkg.sv | 22 ++
 rtl/redmule_z_collector_if.sv | 23 ++
 rtl/redmule_z_row_store.sv | 41 ++++
 rtl/redmule_z_collector.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/redmule_z_collector_pkg.sv
// Shared types for the RedMulE Z collector.
//   z_buffer_flgs_t : full/empty tile-boundary pulses to the controller
//   zcol_state_e    : collector phase (FILL captures rows, DRAIN streams them out)
//   zbuf_strb_w()   : byte-strobe width of one output row
package redmule_pkg;

    typedef struct packed {
        logic full;
        logic empty;
    } z_buffer_flgs_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } zcol_state_e;

    function automatic int unsigned zbuf_strb_w(input int unsigned data_w,
                                                input int unsigned elems);
        return elems * data_w / 8;
    endfunction

endpackage

// File: rtl/redmule_z_collector_if.sv
// Row stream from the Z collector to the Z store streamer.
//   data  : one drained row (ROW_ELEMS x DATA_W)
//   strb  : byte strobes for the valid elements of the row
//   valid : row valid, held with stable data until accepted
//   ready : streamer accepts the row
// modport master = collector side, modport slave = streamer side.
interface redmule_z_collector_if #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ROW_ELEMS = 4
) ();
    import redmule_pkg::*;

    localparam int unsigned STRB_W = zbuf_strb_w(DATA_W, ROW_ELEMS);

    logic [ROW_ELEMS*DATA_W-1:0] data;
    logic [STRB_W-1:0]           strb;
    logic                        valid;
    logic                        ready;

    modport master (output data, strb, valid, input ready);
    modport slave  (input data, strb, valid, output ready);

endinterface

// File: rtl/redmule_z_row_store.sv
// DEPTH x row flop array with one write port and one registered read port.
//   clk_i, rst_ni, clear_i : clock, sync active-low reset, sync soft clear
//   we_i, waddr_i, wdata_i : write port
//   re_i, raddr_i          : read enable / address (caller passes next read pointer)
//   rdata_o                : registered read data, zero after reset/clear
// Storage itself is not reset; only the read register is.
module redmule_z_row_store #(
    parameter int unsigned ROW_W = 64,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [ROW_W-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [ROW_W-1:0] rdata_o
);

    logic [DEPTH-1:0][ROW_W-1:0] mem_q;
    logic [ROW_W-1:0]            rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // A one-row tile writes slot 0 in the same cycle it starts draining it,
    // so forward the write data into the read register in that case.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i)
            rdata_q <= '0;
        else if (re_i)
            rdata_q <= (we_i && waddr_i == raddr_i) ? wdata_i : mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/redmule_z_collector.sv
// Output-side tile buffer between the RedMulE engine and the Z store streamer.
// Captures one row per accepted fill until the programmed row count is
// reached, pulses full, drains the rows over a valid/ready stream, then
// pulses empty and returns to capturing.
//   clk_i, rst_ni, clear_i : clock, sync active-low reset, sync soft clear
//   clk_en_i, fill_i, row_i: capture enable, capture strobe, engine row
//   rows_i, cols_i         : rows per tile / valid elements per row (0 = max)
//   z_o                    : drained row stream (master)
//   flgs_o, ovf_o          : full/empty pulses, sticky dropped-fill flag
//   drop_cnt_o             : saturating dropped-fill count when
//                            REDMULE_ZBUF_DROP_CNT_EN is defined, else 0
module redmule_z_collector
    import redmule_pkg::*;
#(
    parameter  int unsigned DATA_W    = 16,
    parameter  int unsigned ROW_ELEMS = 4,
    parameter  int unsigned DEPTH     = 8,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1),
    localparam int unsigned COL_W     = $clog2(ROW_ELEMS + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        clk_en_i,
    input  logic                        fill_i,
    input  logic [ROW_ELEMS*DATA_W-1:0] row_i,
    input  logic [CNT_W-1:0]            rows_i,
    input  logic [COL_W-1:0]            cols_i,
    redmule_z_collector_if.master       z_o,
    output z_buffer_flgs_t              flgs_o,
    output logic                        ovf_o,
    output logic [15:0]                 drop_cnt_o
);

    localparam int unsigned ROW_W  = ROW_ELEMS * DATA_W;
    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned BPE    = DATA_W / 8;
    localparam int unsigned STRB_W = zbuf_strb_w(DATA_W, ROW_ELEMS);

    zcol_state_e      state_q, state_d;
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] rows_lat_q, rows_lat_d, rows_eff, rows_cur;
    logic [COL_W-1:0] cols_lat_q, cols_lat_d, cols_eff;
    logic             full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
    logic             wr_en, last_wr, hs, last_rd, drop, soft_rst;
    logic [ROW_W-1:0] rdata;
    logic [STRB_W-1:0] strb;

    assign soft_rst = !rst_ni || clear_i;

    always_comb begin
        rows_eff = (rows_i == '0 || rows_i > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : rows_i;
        cols_eff = (cols_i == '0 || cols_i > COL_W'(ROW_ELEMS)) ? COL_W'(ROW_ELEMS) : cols_i;
        // Tile geometry comes from the ports only on the first row of a tile.
        rows_cur = (wr_ptr_q == '0) ? rows_eff : rows_lat_q;
        wr_en    = (state_q == FILL) && fill_i && clk_en_i;
        last_wr  = wr_en && (wr_ptr_q + CNT_W'(1) == rows_cur);
        hs       = (state_q == DRAIN) && z_o.ready;
        last_rd  = hs && (rd_ptr_q == rows_lat_q - CNT_W'(1));
        drop     = (state_q == DRAIN) && fill_i && clk_en_i;
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rows_lat_d = rows_lat_q;
        cols_lat_d = cols_lat_q;
        full_d     = last_wr;
        empty_d    = last_rd;
        ovf_d      = ovf_q | drop;
        case (state_q)
            FILL: if (wr_en) begin
                if (wr_ptr_q == '0) begin
                    rows_lat_d = rows_eff;
                    cols_lat_d = cols_eff;
                end
                if (last_wr) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    state_d  = DRAIN;
                end else begin
                    wr_ptr_d = wr_ptr_q + CNT_W'(1);
                end
            end
            DRAIN: if (hs) begin
                if (last_rd) begin
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    state_d  = FILL;
                end else begin
                    rd_ptr_d = rd_ptr_q + CNT_W'(1);
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            state_q    <= FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rows_lat_q <= '0;
            cols_lat_q <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rows_lat_q <= rows_lat_d;
            cols_lat_q <= cols_lat_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ovf_q      <= ovf_d;
        end
    end

    // Reading at the next read pointer keeps the output register one step
    // ahead, so the first row is presented in the cycle DRAIN is entered.
    redmule_z_row_store #(.ROW_W(ROW_W), .DEPTH(DEPTH), .AW(AW)) i_store (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (row_i),
        .re_i    (state_d == DRAIN),
        .raddr_i (rd_ptr_d[AW-1:0]),
        .rdata_o (rdata)
    );

    always_comb begin
        strb = '0;
        for (int e = 0; e < ROW_ELEMS; e++)
            if (state_q == DRAIN && COL_W'(e) < cols_lat_q) strb[e*BPE +: BPE] = '1;
    end

    assign z_o.data  = rdata;
    assign z_o.strb  = strb;
    assign z_o.valid = (state_q == DRAIN);
    assign flgs_o    = '{full: full_q, empty: empty_q};
    assign ovf_o     = ovf_q;

`ifdef REDMULE_ZBUF_DROP_CNT_EN
    logic [15:0] drop_cnt_q;
    always_ff @(posedge clk_i) begin
        if (soft_rst)
            drop_cnt_q <= '0;
        else if (drop && drop_cnt_q != 16'hFFFF)
            drop_cnt_q <= drop_cnt_q + 16'd1;
    end
    assign drop_cnt_o = drop_cnt_q;
`else
    assign drop_cnt_o = '0;
`endif

endmodule
